// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bundle between pc_fetch and the memory.
//   imem_req   : fetch request (pc_fetch -> memory)
//   imem_addr  : fetch address (pc_fetch -> memory)
//   imem_ready : response valid / request complete (memory -> pc_fetch)
//   imem_rdata : fetched instruction word (memory -> pc_fetch)
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch unit.
// Fetches one instruction at PC, holds it for decode until it retires,
// then advances PC according to the next-PC select.
//   clk, rst     : clock, asynchronous active-high reset
//   NPCOp        : next-PC select (000 seq, 001 branch, 010 jal, 100 jalr)
//   IMM, ALUOut  : branch/jal offset, jalr target
//   retire       : held instruction finished; NPCOp/IMM/ALUOut valid
//   stall        : freeze all state
//   imem         : instruction memory request/response (master side)
//   inst         : held instruction, inst_valid marks it awaiting retire
//   PC, PCPLUS4  : address of the held/being-fetched instruction, and PC+4
//   pc_misalign  : sticky, set when a computed next PC was not word aligned
module pc_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] IMM,
  input  logic [31:0] ALUOut,
  input  logic        retire,
  input  logic        stall,
  pc_fetch_if.master  imem,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPLUS4,
  output logic        pc_misalign
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] npc;
  logic        npc_misaligned;
  logic        fetch_done;
  logic        retire_now;
  logic        halt_on_retire;

  always_comb begin
    npc = PC + 32'd4;
    case (NPCOp)
      3'b001,
      3'b010:  npc = PC + IMM;
      3'b100:  npc = {ALUOut[31:1], 1'b0};
      default: npc = PC + 32'd4;
    endcase
  end

  assign npc_misaligned = |npc[1:0];
  assign halt_on_retire = npc_misaligned && ILLEGAL_HALT;
  assign fetch_done     = (state == FETCH) && imem.imem_ready;
  assign retire_now     = (state == EXEC) && retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else if (!stall) begin
      state <= state_nxt;
    end
  end

  // Request is a pure function of state, so a stall (which freezes state)
  // keeps it unchanged; it is masked while reset is held.
  always_comb begin
    state_nxt     = state;
    imem.imem_req = 1'b0;
    case (state)
      FETCH: begin
        imem.imem_req = !rst;
        if (imem.imem_ready) state_nxt = EXEC;
      end
      EXEC: begin
        if (retire) state_nxt = halt_on_retire ? HALT : FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  assign imem.imem_addr = PC;
  assign PCPLUS4        = PC + 32'd4;

  // Aligned targets already have npc[1:0]==0, so clearing the low bits
  // covers both the normal load and the non-halting misaligned load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC          <= RESET_PC;
      inst        <= 32'h0000_0013;
      inst_valid  <= 1'b0;
      pc_misalign <= 1'b0;
    end else if (!stall) begin
      if (fetch_done) begin
        inst       <= imem.imem_rdata;
        inst_valid <= 1'b1;
      end
      if (retire_now) begin
        inst_valid <= 1'b0;
        if (npc_misaligned) pc_misalign <= 1'b1;
        if (!halt_on_retire) PC <= {npc[31:2], 2'b00};
      end
    end
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter ILLEGAL_HALT, default 1, when 1 a misaligned next PC enters HALT.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 NPCOp  input  3  next-PC select from control decode: 000 seq, 001 branch-taken, 010 jal, 100 jalr.
REQ-006 IMM  input  32  sign-extended immediate for branch/jal offset.
REQ-007 ALUOut  input  32  jalr target (rs1+imm) from ALU.
REQ-008 retire  input  1  downstream has finished executing the held instruction; NPCOp/IMM/ALUOut valid this cycle.
REQ-009 stall  input  1  freeze all state.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  32  instruction fetch address.
REQ-012 imem_ready  input  1  imem_rdata valid this cycle; request complete.
REQ-013 imem_rdata  input  32  fetched instruction word.
REQ-014 inst  output  32  held instruction for decode/control.
REQ-015 inst_valid  output  1  inst is valid and awaiting retire.
REQ-016 PC  output  32  address of the held/being-fetched instruction.
REQ-017 PCPLUS4  output  32  PC+4, link value for jal/jalr writeback.
REQ-018 pc_misalign  output  1  sticky flag: computed next PC had bits[1:0]!=0.

Function
REQ-019 FSM states: FETCH, EXEC, HALT; state register updates only when stall=0.
REQ-020 FETCH: imem_req=1, imem_addr=PC; on imem_ready=1 latch imem_rdata into inst, set inst_valid=1, go EXEC; else remain FETCH with address held stable.
REQ-021 Fetch latency: minimum one cycle from imem_req to inst_valid (ready in first FETCH cycle -> inst_valid asserted next edge).
REQ-022 EXEC: imem_req=0; inst/inst_valid/PC held until retire=1.
REQ-023 On retire=1 in EXEC: PC<=NPC, inst_valid<=0, go FETCH (or HALT per REQ-026).
REQ-024 NPC: 000 -> PC+4; 001 -> PC+IMM; 010 -> PC+IMM; 100 -> {ALUOut[31:1],1'b0}; any other code -> PC+4.
REQ-025 All PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
REQ-026 If NPC[1:0]!=0 at retire: pc_misalign<=1; if ILLEGAL_HALT=1 go HALT with PC unchanged, else load NPC with bits[1:0] cleared and go FETCH.
REQ-027 HALT: imem_req=0, inst_valid=0, retire ignored; exit only by reset.
REQ-028 stall=1 overrides everything: no state, PC, inst or flag change; imem_req keeps its current value; imem_ready while stalled in FETCH is ignored (request reissued).
REQ-029 retire outside EXEC is ignored.
REQ-030 PCPLUS4 combinational = PC+4 at all times.

Reset
REQ-031 rst=1 immediately: PC=RESET_PC, state=FETCH, inst=32'h0000_0013 (nop), inst_valid=0, pc_misalign=0; imem_req=1 as soon as rst deasserts.
REQ-032 Reset mid-fetch or mid-exec aborts the operation; a late imem_ready after reset is treated as a response to the new RESET_PC request only if in FETCH.

Verification
REQ-033 Reset, imem_ready=1 each FETCH, retire with NPCOp=000 three times -> imem_addr sequence 0,4,8,C; PCPLUS4=4,8,C,10.
REQ-034 PC=0x100, retire NPCOp=001 IMM=0xFFFF_FFF8 -> next imem_addr=0xF8; NPCOp=010 IMM=0x20 at PC=0xF8 -> 0x118.
REQ-035 NPCOp=100 ALUOut=0x0000_0203 -> pc_misalign=1, state HALT, imem_req=0 thereafter; ALUOut=0x0000_0201 -> next PC 0x200, no flag.
REQ-036 imem_ready held 0 for 5 cycles, stall=1 for 2 cycles during EXEC with retire=1 -> imem_addr stable, inst_valid stays 1 through stall, single PC advance after stall drops.
REQ-037 PC=0xFFFF_FFFC, retire NPCOp=000 -> PC=0x0000_0000, pc_misalign=0.
REQ-038 Assert rst in EXEC with inst_valid=1 -> same cycle inst_valid=0, PC=RESET_PC; after release fetch restarts at RESET_PC.
